// File: rtl/eth_tx_framer_if.sv
// rtl/eth_tx_framer_if.sv - FIFO read port and byte-stream bus of the TX framer
interface eth_tx_framer_if #(
  parameter int WIDTH = 9
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             r_en;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_sof;
  logic             tx_eof;
  logic             tx_err;
  logic             busy;

  modport master (
    input  fifo_empty, fifo_data,
    output r_en, tx_data, tx_valid, tx_sof, tx_eof, tx_err, busy
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  r_en, tx_data, tx_valid, tx_sof, tx_eof, tx_err, busy
  );
endinterface

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - pops {last,byte} FIFO words and emits preamble, SFD, payload and padding
module eth_tx_framer #(
  parameter int WIDTH   = 9,
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12,
  parameter int CNT_W   = 11
) (
  input  logic           rclk,
  input  logic           arst,
  eth_tx_framer_if.master bus
);
  localparam int IFG_W = $clog2(IFG_LEN + 1);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, DROP, IFG} state_t;

  state_t           state_q, state_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic             fetched_q, fetched_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_sof_q, tx_sof_d;
  logic             tx_eof_q, tx_eof_d;
  logic             tx_err_q, tx_err_d;
  logic             busy_q, busy_d;
  logic             r_en;

  // State names the byte being loaded into the output register, one cycle ahead of tx_*.
  always_comb begin
    cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    cnt_d      = cnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    fetched_d  = 1'b0;
    r_en       = 1'b0;
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    tx_sof_d   = 1'b0;
    tx_eof_d   = 1'b0;
    tx_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          state_d    = PRE;
          tx_valid_d = 1'b1;
          tx_sof_d   = 1'b1;
          tx_data_d  = 8'h55;
          pre_cnt_d  = 3'd1;
          cnt_d      = '0;
        end
      end
      PRE: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h55;
        pre_cnt_d  = pre_cnt_q + 3'd1;
        if (pre_cnt_q == 3'd6) state_d = SFD;
      end
      SFD: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'hD5;
        r_en       = !bus.fifo_empty;
        fetched_d  = !bus.fifo_empty;
        state_d    = DATA;
      end
      DATA: begin
        tx_valid_d = 1'b1;
        if (fetched_q) begin
          tx_data_d = bus.fifo_data[7:0];
          cnt_d     = cnt_inc;
          if (!bus.fifo_data[WIDTH-1]) begin
            r_en      = !bus.fifo_empty;
            fetched_d = !bus.fifo_empty;
          end else if (cnt_q >= CNT_W'(MIN_LEN - 1)) begin
            tx_eof_d  = 1'b1;
            ifg_cnt_d = '0;
            state_d   = IFG;
          end else begin
            state_d = PAD;
          end
        end else begin
          // The byte we needed never arrived: close the frame with an error marker.
          tx_eof_d = 1'b1;
          tx_err_d = 1'b1;
          state_d  = DROP;
        end
      end
      PAD: begin
        tx_valid_d = 1'b1;
        cnt_d      = cnt_inc;
        if (cnt_q == CNT_W'(MIN_LEN - 1)) begin
          tx_eof_d  = 1'b1;
          ifg_cnt_d = '0;
          state_d   = IFG;
        end
      end
      DROP: begin
        if (fetched_q && bus.fifo_data[WIDTH-1]) begin
          ifg_cnt_d = '0;
          state_d   = IFG;
        end else begin
          r_en      = !bus.fifo_empty;
          fetched_d = !bus.fifo_empty;
        end
      end
      IFG: begin
        ifg_cnt_d = ifg_cnt_q + 1'b1;
        if (ifg_cnt_q == IFG_W'(IFG_LEN - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      cnt_q      <= '0;
      ifg_cnt_q  <= '0;
      fetched_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      fetched_q  <= fetched_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.r_en     = r_en;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_sof   = tx_sof_q;
  assign bus.tx_eof   = tx_eof_q;
  assign bus.tx_err   = tx_err_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - directed bench for eth_tx_framer with a frame-level expected-stream model
module tb_eth_tx_framer;
  localparam int MIN_LEN = 60;
  localparam int IFG_LEN = 12;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } rec_t;
  typedef logic [7:0] bq_t[$];

  logic       rclk = 1'b0;
  logic       arst = 1'b1;
  logic       fifo_empty_r = 1'b1;
  logic [8:0] fifo_data_r = 9'h000;

  rec_t       exp_q[$];
  logic [8:0] fq[$];

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops = 0;
  int flushed = 0;
  int eof_count = 0;
  int last_len = 0;
  int last_gap = 0;

  eth_tx_framer_if #(.WIDTH(9)) bus ();

  eth_tx_framer #(.WIDTH(9), .MIN_LEN(MIN_LEN), .IFG_LEN(IFG_LEN), .CNT_W(11)) dut (
    .rclk (rclk),
    .arst (arst),
    .bus  (bus.master)
  );

  assign bus.fifo_empty = fifo_empty_r;
  assign bus.fifo_data  = fifo_data_r;

  always #5 rclk = ~rclk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected byte stream of one frame, straight from the framing rules.
  task automatic model_frame(input bq_t p, input bit abort);
    int n;
    int total;
    n = p.size();
    for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, i == 0, 1'b0, 1'b0});
    exp_q.push_back('{8'hD5, 1'b0, 1'b0, 1'b0});
    if (abort) begin
      for (int i = 0; i < n; i++) exp_q.push_back('{p[i], 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    end else begin
      total = (n < MIN_LEN) ? MIN_LEN : n;
      for (int i = 0; i < total; i++)
        exp_q.push_back('{(i < n) ? p[i] : 8'h00, 1'b0, i == total - 1, 1'b0});
    end
  endtask

  task automatic push_words(input bq_t p, input bit mark_last);
    for (int i = 0; i < p.size(); i++) begin
      fq.push_back({mark_last && (i == p.size() - 1), p[i]});
      pushes++;
    end
  endtask

  task automatic make_bytes(output bq_t p, input int n, input int base);
    p = {};
    for (int i = 0; i < n; i++) p.push_back(8'(base + i));
  endtask

  // FIFO read port: data appears the cycle after a read; writes show up as non-empty one edge later.
  task automatic fifo_model();
    forever begin : step
      int n;
      @(posedge rclk or posedge arst);
      if (arst) begin
        fifo_empty_r <= 1'b1;
      end else begin
        n = fq.size();
        if (bus.r_en && !fifo_empty_r && n > 0) begin
          fifo_data_r <= fq.pop_front();
          pops++;
          n--;
        end
        fifo_empty_r <= (n == 0);
      end
    end
  endtask

  task automatic monitor();
    bit   in_frame = 1'b0;
    bit   have_eof = 1'b0;
    int   flen = 0;
    int   c = 0;
    int   last_eof_cyc = 0;
    rec_t e;
    forever begin
      @(negedge rclk);
      c++;
      if (arst) begin
        in_frame = 1'b0;
        have_eof = 1'b0;
      end else begin
        if (bus.r_en) chk("r_en_while_empty", int'(bus.fifo_empty), 0);
        if (bus.tx_valid) begin
          chk("busy_with_valid", int'(bus.busy), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: actual=0x%0h required=none", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("stream_byte", int'({bus.tx_data, bus.tx_sof, bus.tx_eof, bus.tx_err}), int'(e));
          end
          if (bus.tx_sof) begin
            if (have_eof) begin
              last_gap = c - last_eof_cyc;
              chk("ifg_min_gap", int'(last_gap >= IFG_LEN + 1), 1);
            end
            flen = 0;
            in_frame = 1'b1;
          end
          flen++;
          if (bus.tx_eof) begin
            in_frame = 1'b0;
            have_eof = 1'b1;
            last_eof_cyc = c;
            last_len = flen;
            eof_count++;
          end
        end else if (in_frame) begin
          checks++;
          errors++;
          $display("FAIL valid_contiguous: actual=0 required=1 at cycle %0d", c);
          in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_eof(input int target);
    int b;
    b = 0;
    while (eof_count < target && b < 3000) begin
      @(negedge rclk);
      #1;
      b++;
    end
    chk("eof_within_budget", int'(eof_count >= target), 1);
  endtask

  function automatic int out_vec();
    return int'({bus.r_en, bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.tx_err, bus.busy, bus.tx_data});
  endfunction

  initial begin
    bq_t p;
    bq_t p2;
    int  base;
    int  bad;

    fork
      fifo_model();
      monitor();
    join_none

    repeat (3) @(posedge rclk);
    #1;
    chk("reset_outputs", out_vec(), 0);
    #1 arst = 1'b0;

    // Reset in the middle of the preamble.
    make_bytes(p, 4, 8'hC0);
    model_frame(p, 1'b0);
    push_words(p, 1'b1);
    repeat (4) @(posedge rclk);
    #2;
    chk("pre_valid_before_reset", int'(bus.tx_valid), 1);
    arst = 1'b1;
    #1;
    chk("reset_mid_pre_outputs", out_vec(), 0);
    flushed += fq.size();
    fq.delete();
    exp_q.delete();
    repeat (2) @(posedge rclk);
    #2 arst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge rclk);
      #1;
      if (bus.tx_valid || bus.busy || bus.r_en) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // 64-byte frame: no padding, 72 valid cycles, then a quiet gap.
    make_bytes(p, 64, 0);
    base = exp_q.size();
    model_frame(p, 1'b0);
    chk("model_len_64", exp_q.size() - base, 72);
    push_words(p, 1'b1);
    wait_eof(1);
    chk("frame_len_64", last_len, 72);
    bad = 0;
    repeat (IFG_LEN) begin
      @(negedge rclk);
      #1;
      if (bus.tx_valid) bad++;
    end
    chk("idle_after_frame_64", bad, 0);

    // 10-byte frame padded with 50 zeros.
    make_bytes(p, 10, 8'hA0);
    base = exp_q.size();
    model_frame(p, 1'b0);
    chk("model_len_10", exp_q.size() - base, 68);
    chk("model_eof_on_last_pad", int'(exp_q[exp_q.size() - 1].eof), 1);
    push_words(p, 1'b1);
    wait_eof(2);
    chk("frame_len_10", last_len, 68);

    // Underrun after 5 bytes, tail dropped, next frame follows after the gap.
    make_bytes(p, 5, 8'h11);
    base = exp_q.size();
    model_frame(p, 1'b1);
    chk("model_len_abort", exp_q.size() - base, 14);
    push_words(p, 1'b0);
    wait_eof(3);
    chk("frame_len_abort", last_len, 14);
    make_bytes(p2, 5, 8'h16);
    push_words(p2, 1'b1);
    make_bytes(p, 3, 8'h70);
    model_frame(p, 1'b0);
    push_words(p, 1'b1);
    wait_eof(4);
    chk("frame_len_after_abort", last_len, 68);

    // Two 60-byte frames back to back.
    make_bytes(p, 60, 8'h20);
    model_frame(p, 1'b0);
    push_words(p, 1'b1);
    make_bytes(p, 60, 8'h80);
    model_frame(p, 1'b0);
    push_words(p, 1'b1);
    wait_eof(6);
    chk("b2b_eof_to_sof", last_gap, IFG_LEN + 1);
    chk("frame_len_60", last_len, 68);

    // Single-byte frame.
    make_bytes(p, 1, 8'hEE);
    base = exp_q.size();
    model_frame(p, 1'b0);
    chk("model_len_1", exp_q.size() - base, 68);
    push_words(p, 1'b1);
    wait_eof(7);
    chk("frame_len_1", last_len, 68);

    repeat (20) @(negedge rclk);
    #1;
    chk("expected_drained", exp_q.size(), 0);
    chk("one_read_per_word", pops + flushed, pushes);
    chk("frame_count", eof_count, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
